// File: rtl/flow_rr_mux_if.sv
// Handshake bundle for flow_rr_mux: selection controls, N producer lanes and one consumer lane.
// The master side drives requests and downstream ready; the slave side is the mux itself.
interface flow_rr_mux_if #(
   parameter int WIDTH    = 20,
   parameter int CHANNELS = 32,
   parameter int SEL_W    = 5
);

   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

endinterface

// File: rtl/flow_rr_mux.sv
// Registered N:1 channel selector with valid/ready flow control and either a fixed
// (external select) or round-robin grant; one output word is held until the consumer takes it.
module flow_rr_mux #(
   parameter int WIDTH    = 20,
   parameter int CHANNELS = 32,
   parameter int SEL_W    = 5
) (
   input logic            clk,
   input logic            rst,
   flow_rr_mux_if.slave   bus
);

   logic [WIDTH-1:0]    r_outData;
   logic [SEL_W-1:0]    r_outChan;
   logic                r_outValid;
   logic [SEL_W-1:0]    r_rrPtr;

   logic                w_load;
   logic                w_xfer;
   logic                w_grantOk;
   logic [SEL_W-1:0]    w_grant;
   logic [WIDTH-1:0]    w_grantData;
   logic                w_selValid;
   logic                w_rrFound;
   logic [SEL_W-1:0]    w_rrIdx;
   int                  w_cand;
   logic [SEL_W-1:0]    w_candIdx;
   logic [CHANNELS-1:0] w_inReady;

   // Fixed mode: an out-of-range select simply matches no channel, so it never grants.
   always_comb begin
      w_selValid = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            w_selValid = bus.in_valid[i];
         end
      end
   end

   // Round-robin search starts just after the last winner and visits the last winner last.
   always_comb begin
      w_rrFound = 1'b0;
      w_rrIdx   = r_rrPtr;
      w_cand    = 0;
      w_candIdx = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         w_cand = int'(r_rrPtr) + k;
         if (w_cand >= CHANNELS) begin
            w_cand = w_cand - CHANNELS;
         end
         w_candIdx = SEL_W'(w_cand);
         if (!w_rrFound && bus.in_valid[w_candIdx]) begin
            w_rrFound = 1'b1;
            w_rrIdx   = w_candIdx;
         end
      end
   end

   always_comb begin
      w_grant     = bus.mode ? w_rrIdx : bus.sel;
      w_grantOk   = bus.mode ? w_rrFound : w_selValid;
      w_grantData = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_grant == SEL_W'(i)) begin
            w_grantData = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // out_ready feeds straight through to in_ready so a full stage can refill in the same cycle.
   always_comb begin
      w_load = ~r_outValid | bus.out_ready;
      w_xfer = w_load & w_grantOk;
      for (int i = 0; i < CHANNELS; i++) begin
         w_inReady[i] = w_xfer & (w_grant == SEL_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outChan  <= '0;
         r_rrPtr    <= SEL_W'(CHANNELS - 1);
      end else if (w_load) begin
         r_outValid <= w_grantOk;
         if (w_grantOk) begin
            r_outData <= w_grantData;
            r_outChan <= w_grant;
            if (bus.mode) begin
               r_rrPtr <= w_grant;
            end
         end
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_data  = r_outData;
   assign bus.out_chan  = r_outChan;
   assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_flow_rr_mux.sv
// Self-checking bench for flow_rr_mux: directed scenarios plus randomized traffic on a
// 32x20 instance and a 5x8 (non-power-of-two) instance, compared to a queue-free grant model.
module tb_flow_rr_mux;

   localparam int WA = 20;
   localparam int CA = 32;
   localparam int SA = 5;
   localparam int WB = 8;
   localparam int CB = 5;
   localparam int SB = 3;

   logic clk = 1'b0;
   logic rstA;
   logic rstB;

   int errors = 0;
   int checks = 0;

   logic [WA-1:0] dataA [CA];
   logic [WB-1:0] dataB [CB];

   int mValA, mDataA, mChanA, mPtrA;
   int mValB, mDataB, mChanB, mPtrB;

   int expSeq [6];

   always #5 clk = ~clk;

   flow_rr_mux_if #(.WIDTH(WA), .CHANNELS(CA), .SEL_W(SA)) ifA ();
   flow_rr_mux_if #(.WIDTH(WB), .CHANNELS(CB), .SEL_W(SB)) ifB ();

   flow_rr_mux #(.WIDTH(WA), .CHANNELS(CA), .SEL_W(SA)) dutA (
      .clk (clk),
      .rst (rstA),
      .bus (ifA.slave)
   );

   flow_rr_mux #(.WIDTH(WB), .CHANNELS(CB), .SEL_W(SB)) dutB (
      .clk (clk),
      .rst (rstB),
      .bus (ifB.slave)
   );

   // Grant rule: fixed index if it requests, else the first requester after the last winner.
   function automatic int modelGrant(input int n, input bit mode, input int sel,
                                     input bit [31:0] valid, input int ptr);
      if (!mode) begin
         if (sel < n && valid[sel]) return sel;
         return -1;
      end
      for (int k = 1; k <= n; k++) begin
         int c;
         c = (ptr + k) % n;
         if (valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModelA();
      mValA = 0; mDataA = 0; mChanA = 0; mPtrA = CA - 1;
   endtask

   task automatic resetModelB();
      mValB = 0; mDataB = 0; mChanB = 0; mPtrB = CB - 1;
   endtask

   // Drives one cycle on the 32-channel instance; called just after a rising edge.
   task automatic applyStimulus(input bit mode, input int sel, input bit [31:0] valid,
                                input bit outReady, input string tag);
      int g;
      bit load;
      logic [63:0] expReady;
      ifA.mode      = mode;
      ifA.sel       = SA'(sel);
      for (int i = 0; i < CA; i++) ifA.in_data[i*WA +: WA] = dataA[i];
      ifA.in_valid  = valid;
      ifA.out_ready = outReady;
      @(negedge clk);
      load = (mValA == 0) || outReady;
      g = modelGrant(CA, mode, sel, valid, mPtrA);
      expReady = (load && g >= 0) ? (64'd1 << g) : 64'd0;
      checkOutput({tag, ".inReady"}, 64'(ifA.in_ready), expReady);
      if (load) begin
         if (g >= 0) begin
            mValA = 1; mDataA = int'(dataA[g]); mChanA = g;
            if (mode) mPtrA = g;
         end else begin
            mValA = 0;
         end
      end
      @(posedge clk);
      #1;
      checkOutput({tag, ".outValid"}, 64'(ifA.out_valid), 64'(mValA));
      checkOutput({tag, ".outData"},  64'(ifA.out_data),  64'(mDataA));
      checkOutput({tag, ".outChan"},  64'(ifA.out_chan),  64'(mChanA));
   endtask

   task automatic applyStimulusSmall(input bit mode, input int sel, input bit [31:0] valid,
                                     input bit outReady, input string tag);
      int g;
      bit load;
      logic [63:0] expReady;
      ifB.mode      = mode;
      ifB.sel       = SB'(sel);
      for (int i = 0; i < CB; i++) ifB.in_data[i*WB +: WB] = dataB[i];
      ifB.in_valid  = valid[CB-1:0];
      ifB.out_ready = outReady;
      @(negedge clk);
      load = (mValB == 0) || outReady;
      g = modelGrant(CB, mode, sel, valid & 32'h1F, mPtrB);
      expReady = (load && g >= 0) ? (64'd1 << g) : 64'd0;
      checkOutput({tag, ".inReady"}, 64'(ifB.in_ready), expReady);
      if (load) begin
         if (g >= 0) begin
            mValB = 1; mDataB = int'(dataB[g]); mChanB = g;
            if (mode) mPtrB = g;
         end else begin
            mValB = 0;
         end
      end
      @(posedge clk);
      #1;
      checkOutput({tag, ".outValid"}, 64'(ifB.out_valid), 64'(mValB));
      checkOutput({tag, ".outData"},  64'(ifB.out_data),  64'(mDataB));
      checkOutput({tag, ".outChan"},  64'(ifB.out_chan),  64'(mChanB));
   endtask

   initial begin
      int selList [5];
      rstA = 1'b1;
      rstB = 1'b1;
      ifA.mode = 1'b0; ifA.sel = '0; ifA.in_data = '0; ifA.in_valid = '0; ifA.out_ready = 1'b0;
      ifB.mode = 1'b0; ifB.sel = '0; ifB.in_data = '0; ifB.in_valid = '0; ifB.out_ready = 1'b0;
      resetModelA();
      resetModelB();

      $display("[TB] reset state");
      @(posedge clk);
      #1;
      checkOutput("reset.outValid", 64'(ifA.out_valid), 64'd0);
      checkOutput("reset.outData",  64'(ifA.out_data),  64'd0);
      checkOutput("reset.outChan",  64'(ifA.out_chan),  64'd0);
      rstA = 1'b0;

      $display("[TB] fixed select sweep");
      for (int i = 0; i < CA; i++) dataA[i] = WA'(i);
      selList = '{0, 1, 2, 4, 31};
      foreach (selList[j]) begin
         applyStimulus(1'b0, selList[j], 32'hFFFF_FFFF, 1'b1, "fixed");
         checkOutput("fixed.chanIsSel", 64'(ifA.out_chan), 64'(selList[j]));
         checkOutput("fixed.dataIsSel", 64'(ifA.out_data), 64'(selList[j]));
      end

      $display("[TB] stall with round-robin");
      applyStimulus(1'b1, 0, 32'hFFFF_FFFF, 1'b1, "stallLoad");
      checkOutput("stallLoad.chan", 64'(ifA.out_chan), 64'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 0, 32'hFFFF_FFFF, 1'b0, "stall");
         checkOutput("stall.held", 64'(ifA.out_valid), 64'd1);
      end
      applyStimulus(1'b1, 0, 32'hFFFF_FFFF, 1'b1, "stallRelease");
      checkOutput("stallRelease.chan", 64'(ifA.out_chan), 64'd1);

      $display("[TB] round-robin over channels 3,7,31");
      expSeq = '{3, 7, 31, 3, 7, 31};
      foreach (expSeq[j]) begin
         applyStimulus(1'b1, 0, 32'h8000_0088, 1'b1, "rr3");
         checkOutput("rr3.seq", 64'(ifA.out_chan), 64'(expSeq[j]));
         checkOutput("rr3.valid", 64'(ifA.out_valid), 64'd1);
      end

      $display("[TB] fixed select on idle channel");
      applyStimulus(1'b0, 5, 32'hFFFF_FFDF, 1'b1, "idleSel");
      applyStimulus(1'b0, 5, 32'hFFFF_FFDF, 1'b1, "idleSel");
      checkOutput("idleSel.drained", 64'(ifA.out_valid), 64'd0);
      dataA[5] = 20'hFFFFF;
      applyStimulus(1'b0, 5, 32'hFFFF_FFFF, 1'b1, "selFull");
      checkOutput("selFull.data", 64'(ifA.out_data), 64'hFFFFF);
      checkOutput("selFull.chan", 64'(ifA.out_chan), 64'd5);

      $display("[TB] asynchronous reset mid-stream");
      applyStimulus(1'b1, 0, 32'hFFFF_FFFF, 1'b0, "preReset");
      #2;
      rstA = 1'b1;
      #1;
      resetModelA();
      checkOutput("asyncRst.outValid", 64'(ifA.out_valid), 64'd0);
      checkOutput("asyncRst.outData",  64'(ifA.out_data),  64'd0);
      @(posedge clk);
      #1;
      rstA = 1'b0;
      applyStimulus(1'b1, 0, 32'hFFFF_FFFF, 1'b1, "postReset");
      checkOutput("postReset.chan", 64'(ifA.out_chan), 64'd0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 300; n++) begin
         bit [31:0] v;
         for (int i = 0; i < CA; i++) dataA[i] = WA'($urandom);
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom & $urandom & $urandom;
            2: v = 32'd1 << $urandom_range(0, 31);
            default: v = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & $urandom);
         endcase
         applyStimulus(1'($urandom), int'($urandom_range(0, 31)), v,
                       ($urandom_range(0, 3) != 0), "rand");
      end

      $display("[TB] five-channel instance");
      for (int i = 0; i < CB; i++) dataB[i] = WB'(8'h10 + 3*i);
      checkOutput("resetB.outValid", 64'(ifB.out_valid), 64'd0);
      checkOutput("resetB.outChan",  64'(ifB.out_chan),  64'd0);
      rstB = 1'b0;
      expSeq = '{0, 1, 2, 3, 4, 0};
      foreach (expSeq[j]) begin
         applyStimulusSmall(1'b1, 0, 32'h1F, 1'b1, "rr5");
         checkOutput("rr5.seq", 64'(ifB.out_chan), 64'(expSeq[j]));
      end
      applyStimulusSmall(1'b0, 6, 32'h1F, 1'b1, "sel6");
      applyStimulusSmall(1'b0, 6, 32'h1F, 1'b1, "sel6");
      checkOutput("sel6.noGrant", 64'(ifB.out_valid), 64'd0);
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < CB; i++) dataB[i] = WB'($urandom);
         applyStimulusSmall(1'($urandom), int'($urandom_range(0, 7)), $urandom & 32'h1F,
                            ($urandom_range(0, 2) != 0), "randB");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
